// File: rtl/hiscore_ram_arbiter.sv
// Lends the game work-RAM port to the hiscore engine: pause the CPU, wait for its
// acknowledge, grant bounded bursts, then hand the port back for a CPU window.
module hiscore_ram_arbiter #(
  parameter int AW          = 10,
  parameter int MAX_BURST   = 32,
  parameter int CPU_WINDOW  = 16,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_dout,
  input  logic          cpu_we,
  output logic          cpu_pause,
  input  logic          cpu_pause_ack,
  input  logic          hs_req,
  input  logic [AW-1:0] hs_addr,
  input  logic [7:0]    hs_dout,
  input  logic          hs_we,
  output logic          hs_grant,
  output logic          hs_din_valid,
  output logic          hs_abort,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_din,
  output logic          ram_we
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int CW = $clog2(CPU_WINDOW + 1);
  localparam logic [7:0]    ACK_LAST   = 8'(ACK_TIMEOUT);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
  localparam logic [CW-1:0] COOL_LAST  = CW'(CPU_WINDOW - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PAUSE = 2'd1,
    GRANT = 2'd2,
    COOL  = 2'd3
  } state_t;

  state_t        state_r;
  logic [7:0]    ack_cnt_r;
  logic [BW-1:0] burst_cnt_r;
  logic [CW-1:0] cool_cnt_r;

  // Arbitration FSM; all handshake outputs are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      cpu_pause    <= 1'b0;
      hs_grant     <= 1'b0;
      hs_din_valid <= 1'b0;
      hs_abort     <= 1'b0;
      ack_cnt_r    <= 8'd0;
      burst_cnt_r  <= '0;
      cool_cnt_r   <= '0;
    end else begin
      hs_abort     <= 1'b0;
      hs_din_valid <= hs_grant & ~hs_we;
      case (state_r)
        IDLE: begin
          if (hs_req) begin
            state_r   <= PAUSE;
            cpu_pause <= 1'b1;
            ack_cnt_r <= 8'd0;
          end
        end
        PAUSE: begin
          // A dropped request is a clean release and outranks the timeout.
          if (!hs_req) begin
            state_r   <= IDLE;
            cpu_pause <= 1'b0;
          end else if (cpu_pause_ack) begin
            state_r     <= GRANT;
            hs_grant    <= 1'b1;
            burst_cnt_r <= '0;
          end else if (ack_cnt_r == ACK_LAST) begin
            state_r   <= IDLE;
            cpu_pause <= 1'b0;
            hs_abort  <= 1'b1;
          end else begin
            ack_cnt_r <= ack_cnt_r + 8'd1;
          end
        end
        GRANT: begin
          // Losing the CPU acknowledge mid-burst is a bus hazard, so it is checked first.
          if (!cpu_pause_ack) begin
            state_r   <= IDLE;
            hs_grant  <= 1'b0;
            cpu_pause <= 1'b0;
            hs_abort  <= 1'b1;
          end else if (!hs_req) begin
            state_r   <= IDLE;
            hs_grant  <= 1'b0;
            cpu_pause <= 1'b0;
          end else if (burst_cnt_r == BURST_LAST) begin
            state_r    <= COOL;
            hs_grant   <= 1'b0;
            cpu_pause  <= 1'b0;
            cool_cnt_r <= '0;
          end else begin
            burst_cnt_r <= burst_cnt_r + BW'(1);
          end
        end
        COOL: begin
          if (cool_cnt_r == COOL_LAST) begin
            if (hs_req) begin
              state_r   <= PAUSE;
              cpu_pause <= 1'b1;
              ack_cnt_r <= 8'd0;
            end else begin
              state_r <= IDLE;
            end
          end else begin
            cool_cnt_r <= cool_cnt_r + CW'(1);
          end
        end
        default: begin
          state_r   <= IDLE;
          cpu_pause <= 1'b0;
          hs_grant  <= 1'b0;
        end
      endcase
    end
  end

  // RAM port mux; a hiscore write is suppressed while reset is asserted.
  always_comb begin
    if (hs_grant) begin
      ram_addr = hs_addr;
      ram_din  = hs_dout;
      ram_we   = hs_we & ~reset;
    end else begin
      ram_addr = cpu_addr;
      ram_din  = cpu_dout;
      ram_we   = cpu_we;
    end
  end

endmodule

// File: tb/tb_hiscore_ram_arbiter.sv
// Directed bench for hiscore_ram_arbiter with short burst, window and timeout settings.
module tb_hiscore_ram_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] cpu_addr;
  logic [7:0] cpu_dout;
  logic       cpu_we;
  logic       cpu_pause;
  logic       cpu_pause_ack;
  logic       hs_req;
  logic [9:0] hs_addr;
  logic [7:0] hs_dout;
  logic       hs_we;
  logic       hs_grant;
  logic       hs_din_valid;
  logic       hs_abort;
  logic [9:0] ram_addr;
  logic [7:0] ram_din;
  logic       ram_we;

  int n_total = 0;
  int n_pass  = 0;

  hiscore_ram_arbiter #(
    .AW(10), .MAX_BURST(4), .CPU_WINDOW(2), .ACK_TIMEOUT(8)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_we(cpu_we),
    .cpu_pause(cpu_pause), .cpu_pause_ack(cpu_pause_ack),
    .hs_req(hs_req), .hs_addr(hs_addr), .hs_dout(hs_dout), .hs_we(hs_we),
    .hs_grant(hs_grant), .hs_din_valid(hs_din_valid), .hs_abort(hs_abort),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; cpu_addr = 10'd0; cpu_dout = 8'd0; cpu_we = 1'b0;
    cpu_pause_ack = 1'b0; hs_req = 1'b0; hs_addr = 10'd0; hs_dout = 8'd0; hs_we = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_pause", 32'(cpu_pause), 32'd0);
    chk("rst_grant", 32'(hs_grant), 32'd0);
    chk("rst_valid", 32'(hs_din_valid), 32'd0);
    chk("rst_abort", 32'(hs_abort), 32'd0);

    // 1: CPU owns the port while idle
    cpu_addr = 10'h010; cpu_dout = 8'h5A; cpu_we = 1'b1; #1;
    chk("idle_we", 32'(ram_we), 32'd1);
    chk("idle_addr", 32'(ram_addr), 32'h010);
    chk("idle_din", 32'(ram_din), 32'h5A);
    tick();
    chk("idle_pause", 32'(cpu_pause), 32'd0);
    cpu_we = 1'b0;

    // 2: basic grant, acknowledge arrives on the third PAUSE cycle
    hs_req = 1'b1;
    tick();
    chk("b_pause", 32'(cpu_pause), 32'd1);
    chk("b_nogrant0", 32'(hs_grant), 32'd0);
    tick(); tick();
    cpu_pause_ack = 1'b1;
    chk("b_nogrant1", 32'(hs_grant), 32'd0);
    tick();
    chk("b_grant", 32'(hs_grant), 32'd1);
    hs_addr = 10'h020; hs_dout = 8'hA5; hs_we = 1'b1; #1;
    chk("b_we", 32'(ram_we), 32'd1);
    chk("b_addr", 32'(ram_addr), 32'h020);
    chk("b_din", 32'(ram_din), 32'hA5);
    tick();
    hs_we = 1'b0; hs_req = 1'b0;
    chk("b_grant2", 32'(hs_grant), 32'd1);
    chk("b_valid_wr", 32'(hs_din_valid), 32'd0);
    tick();
    chk("b_rel_grant", 32'(hs_grant), 32'd0);
    chk("b_rel_pause", 32'(cpu_pause), 32'd0);
    chk("b_valid_rd", 32'(hs_din_valid), 32'd1);
    tick();
    chk("b_valid_end", 32'(hs_din_valid), 32'd0);

    // 3: burst limit of 4, CPU window of 2, then re-pause
    hs_req = 1'b1;
    tick();
    chk("l_pause", 32'(cpu_pause), 32'd1);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("l_grant%0d", i), 32'(hs_grant), 32'd1);
      tick();
    end
    chk("l_cool_grant", 32'(hs_grant), 32'd0);
    chk("l_cool_pause", 32'(cpu_pause), 32'd0);
    cpu_addr = 10'h040; cpu_dout = 8'h77; cpu_we = 1'b1; #1;
    chk("l_cpu_we", 32'(ram_we), 32'd1);
    chk("l_cpu_addr", 32'(ram_addr), 32'h040);
    tick();
    cpu_we = 1'b0;
    chk("l_cool2_pause", 32'(cpu_pause), 32'd0);
    chk("l_cool2_grant", 32'(hs_grant), 32'd0);
    tick();
    chk("l_repause", 32'(cpu_pause), 32'd1);
    chk("l_repause_grant", 32'(hs_grant), 32'd0);
    tick();
    chk("l_regrant", 32'(hs_grant), 32'd1);
    hs_req = 1'b0;
    tick();
    chk("l_end_grant", 32'(hs_grant), 32'd0);

    // 5: granted read, valid follows one cycle later
    hs_req = 1'b1; hs_addr = 10'h030; hs_we = 1'b0;
    tick(); tick();
    chk("r_grant", 32'(hs_grant), 32'd1);
    chk("r_valid0", 32'(hs_din_valid), 32'd0);
    chk("r_addr", 32'(ram_addr), 32'h030);
    hs_req = 1'b0;
    tick();
    chk("r_grant_off", 32'(hs_grant), 32'd0);
    chk("r_valid1", 32'(hs_din_valid), 32'd1);
    tick();
    chk("r_valid_off", 32'(hs_din_valid), 32'd0);

    // 4: acknowledge never comes, abort after 9 PAUSE cycles
    cpu_pause_ack = 1'b0; hs_req = 1'b1;
    tick();
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("t_pause%0d", i), 32'(cpu_pause), 32'd1);
      chk($sformatf("t_noabort%0d", i), 32'(hs_abort), 32'd0);
      tick();
    end
    chk("t_abort", 32'(hs_abort), 32'd1);
    chk("t_idle_pause", 32'(cpu_pause), 32'd0);
    hs_req = 1'b0;
    tick();
    chk("t_abort_pulse", 32'(hs_abort), 32'd0);
    chk("t_stay_idle", 32'(cpu_pause), 32'd0);

    // 6: reset in the middle of a granted write
    cpu_pause_ack = 1'b1; hs_req = 1'b1;
    tick(); tick();
    hs_we = 1'b1; hs_addr = 10'h050; cpu_addr = 10'h060; cpu_we = 1'b0; #1;
    chk("x_grant", 32'(hs_grant), 32'd1);
    chk("x_hs_we", 32'(ram_we), 32'd1);
    reset = 1'b1; #1;
    chk("x_we_in_reset", 32'(ram_we), 32'd0);
    tick();
    chk("x_grant_off", 32'(hs_grant), 32'd0);
    chk("x_pause_off", 32'(cpu_pause), 32'd0);
    cpu_we = 1'b1; #1;
    chk("x_cpu_we1", 32'(ram_we), 32'd1);
    chk("x_cpu_addr", 32'(ram_addr), 32'h060);
    cpu_we = 1'b0; #1;
    chk("x_cpu_we0", 32'(ram_we), 32'd0);
    reset = 1'b0; hs_req = 1'b0; hs_we = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
